seq_detect_prog: RTL and testbench
==================================

// Module: seq_detect_prog
// PURPOSE
//  Programmable serial bit-pattern detector, successor to the fixed 1011 FSM detector.
//  Matches a runtime-loaded pattern of 1..MAX_LEN bits on a valid-qualified serial stream.
//  Supports overlapping and non-overlapping match modes and keeps a saturating match counter.
//  Sits between the serial deserialiser front-end and the event/interrupt logic.
// PARAMETERS
//  MAX_LEN      8        longest supported pattern, in bits (>=2)
//  LEN_W        4        width of cfg_len; must hold MAX_LEN
//  CNT_W        8        match counter width
//  DEF_PATTERN  8'h0B    pattern after reset (LSB-aligned; default 1011)
//  DEF_LEN      4        pattern length after reset
//  DEF_OVERLAP  1        overlap mode after reset
// PORTS
//  clk          in   1        clock, all logic on rising edge
//  reset        in   1        synchronous, active-high
//  cfg_load     in   1        one-cycle strobe: latch cfg_pattern/cfg_len/cfg_overlap
//  cfg_pattern  in   MAX_LEN  pattern; bit [len-1] = first bit received, bit [0] = last
//  cfg_len      in   LEN_W    pattern length; valid range 1..MAX_LEN
//  cfg_overlap  in   1        1 = overlapping matches allowed, 0 = restart after each match
//  in_valid     in   1        in_bit is sampled only when high
//  in_bit       in   1        serial data
//  cnt_clr      in   1        clear match_count
//  seq_seen     out  1        one-cycle pulse per detected match
//  match_count  out  CNT_W    saturating number of matches since last clear/load/reset
//  cnt_sat      out  1        high while match_count == all ones
//  cfg_err      out  1        high while the active cfg_len is invalid (0 or > MAX_LEN)
// BEHAVIOUR
//  - Reset: pattern/len/overlap <= DEF_*; history <= 0; fill <= 0; all outputs 0.
//  - State: history shift reg hist[MAX_LEN-1:0]; fill counter (0..MAX_LEN, saturating) = number of
//    bits accepted since the last clear.
//  - On in_valid (and no cfg_load): nh = {hist[MAX_LEN-2:0], in_bit}; nf = min(fill+1, MAX_LEN).
//    match = !cfg_err && nf >= len && nh[len-1:0] == pattern[len-1:0]. hist <= nh.
//  - fill update: match && !overlap -> 0 (bits of the matched pattern are not reused);
//    else -> nf.
//  - seq_seen is registered: high exactly the cycle after the accepting in_valid cycle
//    (latency 1); otherwise 0. No in_valid -> no state change and seq_seen = 0.
//  - match_count: +1 per match; holds at 2^CNT_W-1 (no wrap). cnt_clr has priority over a
//    same-cycle match (result 0); seq_seen still pulses for that match.
//  - cfg_load: latches all three cfg_* inputs; clears hist, fill, match_count; seq_seen = 0
//    next cycle. A same-cycle in_valid bit is discarded. cfg_load wins over cnt_clr.
//  - cfg_err = (len == 0 || len > MAX_LEN), evaluated on the latched length. While it is set,
//    no matches occur; hist/fill keep updating. It clears only on a valid cfg_load or reset.
//  - Reset mid-stream abandons any partial match; it does not produce a pulse.
// TESTING
//  1 Reset defaults, overlap: bits 1,0,1,1,0,1,1 (valid every cycle) -> seq_seen after bit 4
//    and bit 7; match_count = 2.
//  2 Load 1011, len 4, overlap=0; same stream -> single pulse after bit 4; match_count = 1.
//  3 Load 111, len 3: stream 1,1,1,1,1 -> overlap=1: 3 pulses (bits 3,4,5);
//    overlap=0: 1 pulse (bit 3).
//  4 in_valid gaps: 1,0,1,1 with idle cycles between bits -> one pulse, only the cycle after
//    the 4th valid bit. A bit sent in the same cycle as cfg_load is ignored.
//  5 CNT_W=2, 5 matches -> count 1,2,3,3,3; cnt_sat from the 3rd match on. Clear on a match
//    cycle -> count 0 with seq_seen pulsing.
//  6 Load len 0 -> cfg_err=1, no pulses on any stream. Load len=MAX_LEN, pattern all ones ->
//    cfg_err=0 and a pulse after MAX_LEN ones. Reset after 1,0,1 then send 1 -> no pulse.

Source files
------------

// File: rtl/seq_detect_prog.sv
// Programmable serial bit-pattern detector with runtime-loaded pattern/length,
// overlapping or restart-after-match modes, and a saturating match counter.
module seq_detect_prog #(
   parameter int                 MAX_LEN     = 8,
   parameter int                 LEN_W       = 4,
   parameter int                 CNT_W       = 8,
   parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'h0B),
   parameter int                 DEF_LEN     = 4,
   parameter bit                 DEF_OVERLAP = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   input  logic               in_valid,
   input  logic               in_bit,
   input  logic               cnt_clr,
   output logic               seq_seen,
   output logic [CNT_W-1:0]   match_count,
   output logic               cnt_sat,
   output logic               cfg_err
);

   logic [MAX_LEN-1:0] pattern_q, pattern_d;
   logic [MAX_LEN-1:0] hist_q, hist_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [LEN_W-1:0]   fill_q, fill_d;
   logic               overlap_q, overlap_d;
   logic               seen_q, seen_d;
   logic [CNT_W-1:0]   count_q, count_d;

   logic [MAX_LEN-1:0] nh;
   logic [MAX_LEN-1:0] mask;
   logic [LEN_W-1:0]   nf;
   logic               len_bad;
   logic               match;

   assign len_bad = (len_q == '0) || (len_q > LEN_W'(MAX_LEN));

   // Only the newest len bits take part in the compare; the mask selects them.
   always_comb begin
      mask = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         mask[i] = (LEN_W'(i) < len_q);
      end
      nh    = {hist_q[MAX_LEN-2:0], in_bit};
      nf    = (fill_q >= LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
      match = in_valid && !cfg_load && !len_bad && (nf >= len_q) &&
              ((nh & mask) == (pattern_q & mask));
   end

   always_comb begin
      pattern_d = pattern_q;
      len_d     = len_q;
      overlap_d = overlap_q;
      hist_d    = hist_q;
      fill_d    = fill_q;
      count_d   = count_q;
      seen_d    = 1'b0;
      if (cfg_load) begin
         pattern_d = cfg_pattern;
         len_d     = cfg_len;
         overlap_d = cfg_overlap;
         hist_d    = '0;
         fill_d    = '0;
         count_d   = '0;
      end else begin
         if (in_valid) begin
            hist_d = nh;
            fill_d = (match && !overlap_q) ? '0 : nf;
            seen_d = match;
         end
         // A clear in the same cycle as a match still wins; the pulse is kept.
         if (cnt_clr) begin
            count_d = '0;
         end else if (match && !(&count_q)) begin
            count_d = count_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pattern_q <= DEF_PATTERN;
         len_q     <= LEN_W'(DEF_LEN);
         overlap_q <= DEF_OVERLAP;
         hist_q    <= '0;
         fill_q    <= '0;
         count_q   <= '0;
         seen_q    <= 1'b0;
      end else begin
         pattern_q <= pattern_d;
         len_q     <= len_d;
         overlap_q <= overlap_d;
         hist_q    <= hist_d;
         fill_q    <= fill_d;
         count_q   <= count_d;
         seen_q    <= seen_d;
      end
   end

   assign seq_seen    = seen_q;
   assign match_count = count_q;
   assign cnt_sat     = &count_q;
   assign cfg_err     = len_bad;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Bench for seq_detect_prog: directed scenarios plus random traffic, checked every
// cycle against a queue-based model of the bits accepted since the last clear.
module tb_seq_detect_prog;

   localparam int MAX_LEN = 8;
   localparam int LEN_W   = 4;

   logic               clk = 1'b0;
   logic               reset;
   logic               cfg_load;
   logic [MAX_LEN-1:0] cfg_pattern;
   logic [LEN_W-1:0]   cfg_len;
   logic               cfg_overlap;
   logic               in_valid;
   logic               in_bit;
   logic               cnt_clr;

   logic               seq_seen, cnt_sat, cfg_err;
   logic [7:0]         match_count;
   logic               seq_seen2, cnt_sat2, cfg_err2;
   logic [1:0]         match_count2;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   seq_detect_prog #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in_bit(in_bit),
      .cnt_clr(cnt_clr), .seq_seen(seq_seen), .match_count(match_count),
      .cnt_sat(cnt_sat), .cfg_err(cfg_err));

   seq_detect_prog #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in_bit(in_bit),
      .cnt_clr(cnt_clr), .seq_seen(seq_seen2), .match_count(match_count2),
      .cnt_sat(cnt_sat2), .cfg_err(cfg_err2));

   // Reference: the bits accepted since the last clear, newest at the back.
   bit         q[$];
   bit [7:0]   m_pat;
   int         m_len;
   bit         m_ovl;
   int         m_cnt, m_cnt2, m_pulses;
   bit         m_seen, m_ready, hit;

   always @(posedge clk) begin
      if (reset) begin
         m_pat = 8'h0B; m_len = 4; m_ovl = 1'b1;
         q.delete();
         m_cnt = 0; m_cnt2 = 0; m_seen = 1'b0; m_ready = 1'b1;
      end else begin
         m_seen = 1'b0;
         if (cfg_load) begin
            m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap;
            q.delete();
            m_cnt = 0; m_cnt2 = 0;
         end else begin
            hit = 1'b0;
            if (in_valid) begin
               q.push_back(in_bit);
               if (q.size() > MAX_LEN) void'(q.pop_front());
               if (m_len >= 1 && m_len <= MAX_LEN && q.size() >= m_len) begin
                  hit = 1'b1;
                  for (int i = 0; i < m_len; i++)
                     if (q[q.size() - m_len + i] != m_pat[m_len - 1 - i]) hit = 1'b0;
               end
               if (hit && !m_ovl) q.delete();
               m_seen = hit;
               if (hit) m_pulses++;
            end
            if (cnt_clr) begin
               m_cnt = 0; m_cnt2 = 0;
            end else if (hit) begin
               if (m_cnt < 255) m_cnt++;
               if (m_cnt2 < 3) m_cnt2++;
            end
         end
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      n_cmp++;
      if (actual != expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Every cycle after the first reset the outputs are compared with the model.
   always @(negedge clk) begin
      if (m_ready) begin
         checkOutput("seq_seen", int'(seq_seen), int'(m_seen));
         checkOutput("match_count", int'(match_count), m_cnt);
         checkOutput("cnt_sat", int'(cnt_sat), int'(m_cnt == 255));
         checkOutput("cfg_err", int'(cfg_err), int'(m_len < 1 || m_len > MAX_LEN));
         checkOutput("seq_seen2", int'(seq_seen2), int'(m_seen));
         checkOutput("match_count2", int'(match_count2), m_cnt2);
         checkOutput("cnt_sat2", int'(cnt_sat2), int'(m_cnt2 == 3));
         checkOutput("cfg_err2", int'(cfg_err2), int'(m_len < 1 || m_len > MAX_LEN));
      end
   end

   task automatic applyStimulus(input logic v, input logic b, input logic ld, input logic clr);
      @(negedge clk);
      #1;
      in_valid = v; in_bit = b; cfg_load = ld; cnt_clr = clr;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1;
      reset = 1'b1; in_valid = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
      @(negedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic send_bits(input logic [15:0] bits, input int n, input int gap);
      for (int i = n - 1; i >= 0; i--) begin
         applyStimulus(1'b1, bits[i], 1'b0, 1'b0);
         repeat (gap) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic load_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                           input logic v, input logic b);
      cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
      applyStimulus(v, b, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   int base;
   int exp_cnt2 [5] = '{1, 2, 3, 3, 3};

   initial begin
      reset = 1'b1; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
      in_valid = 1'b0; in_bit = 1'b0; cnt_clr = 1'b0;
      m_pulses = 0; m_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      reset = 1'b0;

      // Defaults: 1011 with overlap
      checkOutput("reset_count", int'(match_count), 0);
      base = m_pulses;
      send_bits(16'b1011011, 7, 0);
      checkOutput("t1_pulses", m_pulses - base, 2);
      checkOutput("t1_count", int'(match_count), 2);

      // Non-overlapping 1011
      load_cfg(8'h0B, 4'd4, 1'b0, 1'b0, 1'b0);
      base = m_pulses;
      send_bits(16'b1011011, 7, 0);
      checkOutput("t2_pulses", m_pulses - base, 1);
      checkOutput("t2_count", int'(match_count), 1);

      // 111 overlap vs restart
      load_cfg(8'h07, 4'd3, 1'b1, 1'b0, 1'b0);
      base = m_pulses;
      send_bits(16'b11111, 5, 0);
      checkOutput("t3_ovl_pulses", m_pulses - base, 3);
      load_cfg(8'h07, 4'd3, 1'b0, 1'b0, 1'b0);
      base = m_pulses;
      send_bits(16'b11111, 5, 0);
      checkOutput("t3_novl_pulses", m_pulses - base, 1);

      // Bit in the load cycle is dropped; gaps between valid bits
      load_cfg(8'h0B, 4'd4, 1'b1, 1'b1, 1'b1);
      base = m_pulses;
      send_bits(16'b011, 3, 0);
      checkOutput("t4_load_bit", m_pulses - base, 0);
      send_bits(16'b1011, 4, 2);
      checkOutput("t4_gap_pulses", m_pulses - base, 1);

      // Saturation on the 2-bit counter; clear on a match cycle
      load_cfg(8'h01, 4'd1, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
         checkOutput("t5_count2", int'(match_count2), exp_cnt2[k]);
         checkOutput("t5_sat2", int'(cnt_sat2), int'(k >= 2));
      end
      base = m_pulses;
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("t5_clr_count", int'(match_count), 0);
      checkOutput("t5_clr_pulse", m_pulses - base, 1);

      // Invalid length, full-length pattern, reset mid-stream
      load_cfg(8'h0B, 4'd0, 1'b1, 1'b0, 1'b0);
      checkOutput("t6_err", int'(cfg_err), 1);
      base = m_pulses;
      send_bits(16'hB5D3, 16, 0);
      checkOutput("t6_err_pulses", m_pulses - base, 0);
      load_cfg(8'hFF, 4'd8, 1'b1, 1'b0, 1'b0);
      checkOutput("t6_err_clear", int'(cfg_err), 0);
      send_bits(16'hFF, 8, 0);
      checkOutput("t6_full_pulses", m_pulses - base, 1);
      do_reset();
      base = m_pulses;
      send_bits(16'b101, 3, 0);
      do_reset();
      send_bits(16'b1, 1, 0);
      checkOutput("t6_reset_pulses", m_pulses - base, 0);

      // Random traffic with short patterns so matches are frequent
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         #1;
         reset       = ($urandom_range(0, 299) == 0);
         cfg_load    = ($urandom_range(0, 39) == 0);
         cfg_pattern = 8'($urandom);
         cfg_len     = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 9))
                                                   : 4'($urandom_range(1, 3));
         cfg_overlap = 1'($urandom);
         cnt_clr     = ($urandom_range(0, 29) == 0);
         in_valid    = ($urandom_range(0, 9) < 7);
         in_bit      = 1'($urandom);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
